// File: rtl/line_drawer.sv
// rtl/line_drawer.sv - Bresenham line rasteriser emitting one framebuffer write per handshake
module line_drawer #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
   localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               ready,
   input  logic [X_WIDTH-1:0] x1,
   input  logic [Y_WIDTH-1:0] y1,
   input  logic [X_WIDTH-1:0] x2,
   input  logic [Y_WIDTH-1:0] y2,
   output logic [X_WIDTH-1:0] pixel_x,
   output logic [Y_WIDTH-1:0] pixel_y,
   output logic               pixel_write,
   input  logic               pixel_ready
);

   localparam int E_W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
   localparam logic [X_WIDTH:0] H_LIMIT = HOR_ACTIVE_PIXELS[X_WIDTH:0];
   localparam logic [Y_WIDTH:0] V_LIMIT = VER_ACTIVE_PIXELS[Y_WIDTH:0];
   localparam logic [X_WIDTH-1:0] X_ONE = {{(X_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [Y_WIDTH-1:0] Y_ONE = {{(Y_WIDTH-1){1'b0}}, 1'b1};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INIT = 2'd1;
   localparam logic [1:0] S_PLOT = 2'd2;

   logic [1:0]               state;
   logic [X_WIDTH-1:0]       x_cur, x_end;
   logic [Y_WIDTH-1:0]       y_cur, y_end;
   logic signed [E_W-1:0]    dx, dy, err;
   logic                     sx_neg, sy_neg;

   logic signed [E_W-1:0]    x_diff, y_diff, x_abs, y_abs;
   logic signed [E_W:0]      e2, dx_ext, dy_ext;
   logic signed [E_W-1:0]    err_next;
   logic                     step_x, step_y;
   logic                     visible, transfer, at_end;
   logic [X_WIDTH-1:0]       x_next;
   logic [Y_WIDTH-1:0]       y_next;

   // During INIT x_cur/y_cur already hold the start point latched in IDLE
   assign x_diff = $signed({{(E_W-X_WIDTH){1'b0}}, x_end}) - $signed({{(E_W-X_WIDTH){1'b0}}, x_cur});
   assign y_diff = $signed({{(E_W-Y_WIDTH){1'b0}}, y_end}) - $signed({{(E_W-Y_WIDTH){1'b0}}, y_cur});
   assign x_abs  = x_diff[E_W-1] ? -x_diff : x_diff;
   assign y_abs  = y_diff[E_W-1] ? -y_diff : y_diff;

   assign e2       = {err, 1'b0};
   assign dx_ext   = {dx[E_W-1], dx};
   assign dy_ext   = {dy[E_W-1], dy};
   assign step_x   = (e2 >= dy_ext);
   assign step_y   = (e2 <= dx_ext);
   assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
   assign x_next   = sx_neg ? (x_cur - X_ONE) : (x_cur + X_ONE);
   assign y_next   = sy_neg ? (y_cur - Y_ONE) : (y_cur + Y_ONE);

   // Off-screen points still advance the walk, they just never reach the framebuffer
   assign visible  = ({1'b0, x_cur} < H_LIMIT) && ({1'b0, y_cur} < V_LIMIT);
   assign transfer = (state == S_PLOT) && (visible ? pixel_ready : 1'b1);
   assign at_end   = (x_cur == x_end) && (y_cur == y_end);

   assign ready       = (state == S_IDLE);
   assign pixel_write = (state == S_PLOT) && visible;
   assign pixel_x     = x_cur;
   assign pixel_y     = y_cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         x_cur  <= '0;
         y_cur  <= '0;
         x_end  <= '0;
         y_end  <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_cur <= x1;
                  y_cur <= y1;
                  x_end <= x2;
                  y_end <= y2;
                  state <= S_INIT;
               end
            end
            S_INIT: begin
               dx     <= x_abs;
               dy     <= -y_abs;
               err    <= x_abs - y_abs;
               sx_neg <= !(x_cur < x_end);
               sy_neg <= !(y_cur < y_end);
               state  <= S_PLOT;
            end
            S_PLOT: begin
               if (transfer) begin
                  if (at_end) begin
                     state <= S_IDLE;
                  end else begin
                     err <= err_next;
                     if (step_x) x_cur <= x_next;
                     if (step_y) y_cur <= y_next;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_drawer.sv
// tb/tb_line_drawer.sv - scoreboard bench for line_drawer
module tb_line_drawer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       ready;
   logic [9:0] x1, x2, pixel_x;
   logic [8:0] y1, y2, pixel_y;
   logic       pixel_write;
   logic       pixel_ready;

   int errors = 0;
   int checks = 0;
   logic [18:0] exp_q[$];

   line_drawer dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel_write(pixel_write), .pixel_ready(pixel_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_px(input int px, input int py);
      exp_q.push_back({px[9:0], py[8:0]});
   endtask

   // Monitor: pops the scoreboard on every accepted write and checks stall stability
   initial begin
      logic       hold_valid;
      logic [9:0] hold_x;
      logic [8:0] hold_y;
      logic [18:0] e;
      hold_valid = 1'b0;
      hold_x = '0;
      hold_y = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_valid = 1'b0;
         end else begin
            if (hold_valid) begin
               checks++;
               if (!pixel_write || pixel_x != hold_x || pixel_y != hold_y) begin
                  errors++;
                  $display("FAIL stall_hold: got w=%0d (%0d,%0d) expected w=1 (%0d,%0d)",
                           pixel_write, pixel_x, pixel_y, hold_x, hold_y);
               end
            end
            hold_valid = 1'b0;
            if (pixel_write) begin
               if (pixel_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_write: got (%0d,%0d) expected no write", pixel_x, pixel_y);
                  end else begin
                     e = exp_q.pop_front();
                     if (pixel_x != e[18:9] || pixel_y != e[8:0]) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d) expected (%0d,%0d)",
                                 pixel_x, pixel_y, e[18:9], e[8:0]);
                     end
                  end
               end else begin
                  hold_valid = 1'b1;
                  hold_x = pixel_x;
                  hold_y = pixel_y;
               end
            end
         end
      end
   end

   // Called at posedge+1; cycle 0 is the cycle start is high
   task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                           input int exp_cyc, input int restart_at, input int reset_at,
                           input bit toggle);
      bit done;
      done = 1'b0;
      x1 = ax1[9:0]; y1 = ay1[8:0]; x2 = ax2[9:0]; y2 = ay2[8:0];
      for (int j = 0; j < 200; j++) begin
         start = (j == 0) || (j == restart_at);
         if (j == restart_at) begin
            x1 = 10'd50; y1 = 9'd50; x2 = 10'd60; y2 = 9'd60;
         end
         pixel_ready = toggle ? ((j % 3) == 0) : 1'b1;
         if (j == reset_at) begin
            reset = 1'b1;
            #1;
            check("reset_ready", ready, 1);
            check("reset_write", pixel_write, 0);
            done = 1'b1;
            break;
         end
         @(negedge clk);
         if (reset_at < 0) begin
            if (j == 1) check("init_busy", ready, 0);
            if (j == 2) check("first_pixel", pixel_write, 1);
            if (j >= 1 && ready) begin
               check("ready_cycle", j, exp_cyc);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         if (done) break;
      end
      start = 1'b0;
      pixel_ready = 1'b1;
      if (!done) begin
         errors++;
         $display("FAIL timeout: got no ready expected ready at cycle %0d", exp_cyc);
      end
      if (reset_at >= 0) begin
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         repeat (5) begin
            @(posedge clk);
            #1;
         end
      end
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0;
      pixel_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_write", pixel_write, 0);
      check("rst_px", pixel_x, 0);
      check("rst_py", pixel_y, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      push_px(0, 0); push_px(1, 1); push_px(2, 1); push_px(3, 2); push_px(4, 2);
      run_line(0, 0, 4, 2, 7, -1, -1, 1'b0);

      push_px(10, 5); push_px(10, 4); push_px(10, 3); push_px(10, 2); push_px(10, 1);
      run_line(10, 5, 10, 1, 7, -1, -1, 1'b0);

      push_px(3, 3); push_px(2, 2); push_px(1, 1); push_px(0, 0);
      run_line(3, 3, 0, 0, 13, -1, -1, 1'b1);

      for (int y = 470; y < 480; y++) push_px(639, y);
      run_line(639, 470, 639, 500, 33, -1, -1, 1'b0);

      for (int x = 0; x < 18; x++) push_px(x, 0);
      run_line(0, 0, 100, 0, -1, -1, 20, 1'b0);

      push_px(5, 5);
      run_line(5, 5, 5, 5, 3, -1, -1, 1'b0);

      push_px(0, 0); push_px(1, 1); push_px(2, 1); push_px(3, 2); push_px(4, 2);
      run_line(0, 0, 4, 2, 7, 4, -1, 1'b0);

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
